// File: rtl/cps_sound_rom_arb.sv
// Sound-ROM read-port arbiter: shares one external ROM port between the Z80
// (with a one-entry read cache) and the MSM6295 sample fetcher. PCM has priority.
module cps_sound_rom_arb #(
    parameter int unsigned        ROM_AW   = 22,
    parameter logic [ROM_AW-1:0]  Z80_BASE = 22'h000000,
    parameter logic [ROM_AW-1:0]  PCM_BASE = 22'h040000
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    // Z80 side
    input  logic [15:0]       i_z80_addr,
    input  logic              i_z80_rd,
    output logic [7:0]        o_z80_dout,
    output logic              o_z80_wait_n,
    // PCM side
    input  logic [17:0]       i_pcm_addr,
    input  logic              i_pcm_req,
    output logic [7:0]        o_pcm_dout,
    output logic              o_pcm_valid,
    output logic              o_pcm_overrun,
    // ROM port
    output logic [ROM_AW-1:0] o_rom_addr,
    output logic              o_rom_rd,
    input  logic [7:0]        i_rom_din,
    input  logic              i_rom_ack
);

    typedef enum logic [1:0] {StIdle, StRdPcm, StRdZ80} state_e;

    state_e              r_state;
    state_e              w_state_next;
    logic [15:0]         r_c_addr;
    logic [7:0]          r_c_data;
    logic                r_c_valid;
    logic [17:0]         r_p_addr;
    logic                r_p_pend;
    logic [7:0]          r_pcm_dout;
    logic                r_pcm_valid;
    logic                r_pcm_overrun;
    logic [ROM_AW-1:0]   r_rom_addr;
    logic                r_rom_rd;

    logic                w_hit;
    logic                w_issue_pcm;
    logic                w_issue_z80;
    logic                w_fill_pcm;
    logic                w_fill_z80;
    logic [ROM_AW-1:0]   w_pcm_rom_addr;
    logic [ROM_AW-1:0]   w_z80_rom_addr;

    // Operands are zero-extended to ROM_AW; the sum wraps silently.
    assign w_pcm_rom_addr = PCM_BASE + ROM_AW'(r_p_addr);
    assign w_z80_rom_addr = Z80_BASE + ROM_AW'(i_z80_addr);

    assign w_hit         = r_c_valid && (r_c_addr == i_z80_addr);
    assign o_z80_dout    = r_c_data;
    assign o_z80_wait_n  = !(i_z80_rd && !w_hit);
    assign o_pcm_dout    = r_pcm_dout;
    assign o_pcm_valid   = r_pcm_valid;
    assign o_pcm_overrun = r_pcm_overrun;
    assign o_rom_addr    = r_rom_addr;
    assign o_rom_rd      = r_rom_rd;

    // FSM state register
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and one-cycle issue/fill strobes
    always_comb begin
        w_state_next = r_state;
        w_issue_pcm  = 1'b0;
        w_issue_z80  = 1'b0;
        w_fill_pcm   = 1'b0;
        w_fill_z80   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (r_p_pend) begin
                    w_state_next = StRdPcm;
                    w_issue_pcm  = 1'b1;
                end else if (i_z80_rd && !w_hit) begin
                    w_state_next = StRdZ80;
                    w_issue_z80  = 1'b1;
                end
            end
            StRdPcm: begin
                if (i_rom_ack) begin
                    w_state_next = StIdle;
                    w_fill_pcm   = 1'b1;
                end
            end
            StRdZ80: begin
                if (i_rom_ack) begin
                    w_state_next = StIdle;
                    w_fill_z80   = 1'b1;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // ROM port: address and strobe registered at issue, strobe dropped on ack
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_rom_addr <= '0;
            r_rom_rd   <= 1'b0;
        end else if (w_issue_pcm) begin
            r_rom_addr <= w_pcm_rom_addr;
            r_rom_rd   <= 1'b1;
        end else if (w_issue_z80) begin
            r_rom_addr <= w_z80_rom_addr;
            r_rom_rd   <= 1'b1;
        end else if (w_fill_pcm || w_fill_z80) begin
            r_rom_rd   <= 1'b0;
        end
    end

    // Z80 cache: tag captured and invalidated at issue, filled on ack
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_c_addr  <= '0;
            r_c_data  <= '0;
            r_c_valid <= 1'b0;
        end else if (w_issue_z80) begin
            r_c_addr  <= i_z80_addr;
            r_c_valid <= 1'b0;
        end else if (w_fill_z80) begin
            r_c_data  <= i_rom_din;
            r_c_valid <= 1'b1;
        end
    end

    // PCM request slot, result register and sticky overrun flag
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_p_addr      <= '0;
            r_p_pend      <= 1'b0;
            r_pcm_dout    <= '0;
            r_pcm_valid   <= 1'b0;
            r_pcm_overrun <= 1'b0;
        end else begin
            r_pcm_valid <= w_fill_pcm;
            if (w_fill_pcm) begin
                r_pcm_dout <= i_rom_din;
            end
            if (w_issue_pcm) begin
                r_p_pend <= 1'b0;
            end
            // A new request wins over the clear of an entry issued this cycle.
            if (i_pcm_req) begin
                r_p_addr <= i_pcm_addr;
                r_p_pend <= 1'b1;
                if (r_p_pend && !w_issue_pcm) begin
                    r_pcm_overrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cps_sound_rom_arb.sv
// Bench for cps_sound_rom_arb: per-cycle vectors of inputs and expected outputs.
module tb_cps_sound_rom_arb;

    logic        clk;
    logic        rst_n;
    logic [15:0] z80_addr;
    logic        z80_rd;
    logic [7:0]  z80_dout;
    logic        z80_wait_n;
    logic [17:0] pcm_addr;
    logic        pcm_req;
    logic [7:0]  pcm_dout;
    logic        pcm_valid;
    logic        pcm_overrun;
    logic [21:0] rom_addr;
    logic        rom_rd;
    logic [7:0]  rom_din;
    logic        rom_ack;

    int n_checks = 0;
    int n_errors = 0;

    cps_sound_rom_arb #(
        .ROM_AW   (22),
        .Z80_BASE (22'h000000),
        .PCM_BASE (22'h040000)
    ) dut (
        .i_clock       (clk),
        .i_reset_n     (rst_n),
        .i_z80_addr    (z80_addr),
        .i_z80_rd      (z80_rd),
        .o_z80_dout    (z80_dout),
        .o_z80_wait_n  (z80_wait_n),
        .i_pcm_addr    (pcm_addr),
        .i_pcm_req     (pcm_req),
        .o_pcm_dout    (pcm_dout),
        .o_pcm_valid   (pcm_valid),
        .o_pcm_overrun (pcm_overrun),
        .o_rom_addr    (rom_addr),
        .o_rom_rd      (rom_rd),
        .i_rom_din     (rom_din),
        .i_rom_ack     (rom_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        z80_rd;
        logic [15:0] z80_addr;
        logic        pcm_req;
        logic [17:0] pcm_addr;
        logic        rom_ack;
        logic [7:0]  rom_din;
        logic        e_wait_n;
        logic        e_rom_rd;
        logic [21:0] e_rom_addr;
        logic [7:0]  e_z80_dout;
        logic        e_pcm_valid;
        logic [7:0]  e_pcm_dout;
        logic        e_overrun;
    } vec_t;

    function automatic vec_t mk(
        input logic rs, input logic rd, input logic [15:0] za,
        input logic pr, input logic [17:0] pa, input logic ak, input logic [7:0] din,
        input logic ew, input logic er, input logic [21:0] era, input logic [7:0] ezd,
        input logic epv, input logic [7:0] epd, input logic eov);
        vec_t v;
        v.rst_n = rs;  v.z80_rd = rd;  v.z80_addr = za;  v.pcm_req = pr;
        v.pcm_addr = pa;  v.rom_ack = ak;  v.rom_din = din;
        v.e_wait_n = ew;  v.e_rom_rd = er;  v.e_rom_addr = era;  v.e_z80_dout = ezd;
        v.e_pcm_valid = epv;  v.e_pcm_dout = epd;  v.e_overrun = eov;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs just after the edge, compare, then advance a clock.
    task automatic apply(input vec_t v, input string tag);
        rst_n    = v.rst_n;
        z80_rd   = v.z80_rd;
        z80_addr = v.z80_addr;
        pcm_req  = v.pcm_req;
        pcm_addr = v.pcm_addr;
        rom_ack  = v.rom_ack;
        rom_din  = v.rom_din;
        #1;
        chk({tag, ".wait_n"},    32'(z80_wait_n),  32'(v.e_wait_n));
        chk({tag, ".rom_rd"},    32'(rom_rd),      32'(v.e_rom_rd));
        chk({tag, ".rom_addr"},  32'(rom_addr),    32'(v.e_rom_addr));
        chk({tag, ".z80_dout"},  32'(z80_dout),    32'(v.e_z80_dout));
        chk({tag, ".pcm_valid"}, 32'(pcm_valid),   32'(v.e_pcm_valid));
        chk({tag, ".pcm_dout"},  32'(pcm_dout),    32'(v.e_pcm_dout));
        chk({tag, ".overrun"},   32'(pcm_overrun), 32'(v.e_overrun));
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[$];

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        // mk(rst, rd, z80_addr, req, pcm_addr, ack, din,
        //    wait_n, rom_rd, rom_addr, z80_dout, pcm_valid, pcm_dout, overrun)
        // Reset state; wait_n follows !z80_rd.
        tbl.push_back(mk(0, 1, 16'h0123, 0, 0, 0, 0,    0, 0, 22'h0, 8'h00, 0, 8'h00, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 0,    1, 0, 22'h0, 8'h00, 0, 8'h00, 0));
        // Z80 miss at 0x0123, ack two cycles after rom_rd rises: wait_n low 4 cycles.
        tbl.push_back(mk(1, 1, 16'h0123, 0, 0, 0, 0,    0, 0, 22'h000000, 8'h00, 0, 8'h00, 0));
        tbl.push_back(mk(1, 1, 16'h0123, 0, 0, 0, 0,    0, 1, 22'h000123, 8'h00, 0, 8'h00, 0));
        tbl.push_back(mk(1, 1, 16'h0123, 0, 0, 0, 0,    0, 1, 22'h000123, 8'h00, 0, 8'h00, 0));
        tbl.push_back(mk(1, 1, 16'h0123, 0, 0, 1, 8'hA5, 0, 1, 22'h000123, 8'h00, 0, 8'h00, 0));
        tbl.push_back(mk(1, 1, 16'h0123, 0, 0, 0, 0,    1, 0, 22'h000123, 8'hA5, 0, 8'h00, 0));
        // Repeat reads hit: no wait, no ROM cycle.
        tbl.push_back(mk(1, 0, 16'h0123, 0, 0, 0, 0,    1, 0, 22'h000123, 8'hA5, 0, 8'h00, 0));
        tbl.push_back(mk(1, 1, 16'h0123, 0, 0, 0, 0,    1, 0, 22'h000123, 8'hA5, 0, 8'h00, 0));
        tbl.push_back(mk(1, 1, 16'h0123, 0, 0, 0, 0,    1, 0, 22'h000123, 8'hA5, 0, 8'h00, 0));
        tbl.push_back(mk(1, 0, 16'h0123, 0, 0, 0, 0,    1, 0, 22'h000123, 8'hA5, 0, 8'h00, 0));
        // PCM read at top sample address; ack in first rom_rd cycle -> valid 3 cycles after req.
        tbl.push_back(mk(1, 0, 16'h0000, 1, 18'h3FFFF, 0, 0, 1, 0, 22'h000123, 8'hA5, 0, 8'h00, 0));
        tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 0, 0,    1, 0, 22'h000123, 8'hA5, 0, 8'h00, 0));
        tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 8'h5A, 1, 1, 22'h07FFFF, 8'hA5, 0, 8'h00, 0));
        tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 0, 0,    1, 0, 22'h07FFFF, 8'hA5, 1, 8'h5A, 0));
        // Stray ack in idle is ignored.
        tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 8'h77, 1, 0, 22'h07FFFF, 8'hA5, 0, 8'h5A, 0));
        tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 0, 0,    1, 0, 22'h07FFFF, 8'hA5, 0, 8'h5A, 0));

        rst_n = 1'b0;  z80_rd = 1'b0;  z80_addr = '0;  pcm_req = 1'b0;
        pcm_addr = '0;  rom_ack = 1'b0;  rom_din = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("tbl%0d", i));
        end

        // Priority: pending PCM and a Z80 miss meet in idle; PCM first, one idle, then Z80.
        apply(mk(1, 0, 16'h0000, 1, 18'h00010, 0, 0,     1, 0, 22'h07FFFF, 8'hA5, 0, 8'h5A, 0), "prio0");
        apply(mk(1, 1, 16'h0200, 0, 0, 0, 0,            0, 0, 22'h07FFFF, 8'hA5, 0, 8'h5A, 0), "prio1");
        apply(mk(1, 1, 16'h0200, 0, 0, 1, 8'h11,        0, 1, 22'h040010, 8'hA5, 0, 8'h5A, 0), "prio2");
        apply(mk(1, 1, 16'h0200, 0, 0, 0, 0,            0, 0, 22'h040010, 8'hA5, 1, 8'h11, 0), "prio3");
        apply(mk(1, 1, 16'h0200, 0, 0, 1, 8'h22,        0, 1, 22'h000200, 8'hA5, 0, 8'h11, 0), "prio4");
        apply(mk(1, 1, 16'h0200, 0, 0, 0, 0,            1, 0, 22'h000200, 8'h22, 0, 8'h11, 0), "prio5");
        apply(mk(1, 0, 16'h0200, 0, 0, 0, 0,            1, 0, 22'h000200, 8'h22, 0, 8'h11, 0), "prio6");

        // pcm_req in the same cycle as a PCM ack: queued, no overrun.
        apply(mk(1, 0, 16'h0000, 1, 18'h00001, 0, 0,     1, 0, 22'h000200, 8'h22, 0, 8'h11, 0), "b2b0");
        apply(mk(1, 0, 16'h0000, 0, 0, 0, 0,            1, 0, 22'h000200, 8'h22, 0, 8'h11, 0), "b2b1");
        apply(mk(1, 0, 16'h0000, 1, 18'h00002, 1, 8'h55, 1, 1, 22'h040001, 8'h22, 0, 8'h11, 0), "b2b2");
        apply(mk(1, 0, 16'h0000, 0, 0, 0, 0,            1, 0, 22'h040001, 8'h22, 1, 8'h55, 0), "b2b3");
        apply(mk(1, 0, 16'h0000, 0, 0, 1, 8'h66,        1, 1, 22'h040002, 8'h22, 0, 8'h55, 0), "b2b4");
        apply(mk(1, 0, 16'h0000, 0, 0, 0, 0,            1, 0, 22'h040002, 8'h22, 1, 8'h66, 0), "b2b5");

        // Overrun: two requests during a Z80 read; only the second address is read.
        apply(mk(1, 1, 16'h0300, 0, 0, 0, 0,            0, 0, 22'h040002, 8'h22, 0, 8'h66, 0), "ovr0");
        apply(mk(1, 1, 16'h0300, 1, 18'h00100, 0, 0,     0, 1, 22'h000300, 8'h22, 0, 8'h66, 0), "ovr1");
        apply(mk(1, 1, 16'h0300, 1, 18'h00200, 0, 0,     0, 1, 22'h000300, 8'h22, 0, 8'h66, 0), "ovr2");
        apply(mk(1, 1, 16'h0300, 0, 0, 1, 8'h33,        0, 1, 22'h000300, 8'h22, 0, 8'h66, 1), "ovr3");
        apply(mk(1, 0, 16'h0300, 0, 0, 0, 0,            1, 0, 22'h000300, 8'h33, 0, 8'h66, 1), "ovr4");
        apply(mk(1, 0, 16'h0300, 0, 0, 1, 8'h44,        1, 1, 22'h040200, 8'h33, 0, 8'h66, 1), "ovr5");
        apply(mk(1, 0, 16'h0300, 0, 0, 0, 0,            1, 0, 22'h040200, 8'h33, 1, 8'h44, 1), "ovr6");
        apply(mk(1, 0, 16'h0300, 0, 0, 0, 0,            1, 0, 22'h040200, 8'h33, 0, 8'h44, 1), "ovr7");

        // Reset during a Z80 read; late ack ignored, next read misses.
        apply(mk(1, 1, 16'h0400, 0, 0, 0, 0,            0, 0, 22'h040200, 8'h33, 0, 8'h44, 1), "rst0");
        apply(mk(0, 1, 16'h0400, 0, 0, 0, 0,            0, 1, 22'h000400, 8'h33, 0, 8'h44, 1), "rst1");
        apply(mk(1, 0, 16'h0400, 0, 0, 1, 8'h99,        1, 0, 22'h000000, 8'h00, 0, 8'h00, 0), "rst2");
        apply(mk(1, 1, 16'h0400, 0, 0, 0, 0,            0, 0, 22'h000000, 8'h00, 0, 8'h00, 0), "rst3");
        apply(mk(1, 1, 16'h0400, 0, 0, 1, 8'h77,        0, 1, 22'h000400, 8'h00, 0, 8'h00, 0), "rst4");
        apply(mk(1, 1, 16'h0400, 0, 0, 0, 0,            1, 0, 22'h000400, 8'h77, 0, 8'h00, 0), "rst5");
        apply(mk(1, 0, 16'h0400, 0, 0, 0, 0,            1, 0, 22'h000400, 8'h77, 0, 8'h00, 0), "rst6");

        // z80_rd drops mid-read: read completes, cache fills, no extra ROM cycle.
        apply(mk(1, 1, 16'h0500, 0, 0, 0, 0,            0, 0, 22'h000400, 8'h77, 0, 8'h00, 0), "abt0");
        apply(mk(1, 0, 16'h0500, 0, 0, 0, 0,            1, 1, 22'h000500, 8'h77, 0, 8'h00, 0), "abt1");
        apply(mk(1, 0, 16'h0500, 0, 0, 1, 8'h88,        1, 1, 22'h000500, 8'h77, 0, 8'h00, 0), "abt2");
        apply(mk(1, 0, 16'h0500, 0, 0, 0, 0,            1, 0, 22'h000500, 8'h88, 0, 8'h00, 0), "abt3");
        apply(mk(1, 0, 16'h0500, 0, 0, 0, 0,            1, 0, 22'h000500, 8'h88, 0, 8'h00, 0), "abt4");
        apply(mk(1, 1, 16'h0500, 0, 0, 0, 0,            1, 0, 22'h000500, 8'h88, 0, 8'h00, 0), "abt5");
        apply(mk(1, 1, 16'h0500, 0, 0, 0, 0,            1, 0, 22'h000500, 8'h88, 0, 8'h00, 0), "abt6");

        // z80_addr changes mid-read: fill is for the old address, new address re-reads.
        apply(mk(1, 1, 16'h0600, 0, 0, 0, 0,            0, 0, 22'h000500, 8'h88, 0, 8'h00, 0), "chg0");
        apply(mk(1, 1, 16'h0601, 0, 0, 0, 0,            0, 1, 22'h000600, 8'h88, 0, 8'h00, 0), "chg1");
        apply(mk(1, 1, 16'h0601, 0, 0, 1, 8'hAA,        0, 1, 22'h000600, 8'h88, 0, 8'h00, 0), "chg2");
        apply(mk(1, 1, 16'h0601, 0, 0, 0, 0,            0, 0, 22'h000600, 8'hAA, 0, 8'h00, 0), "chg3");
        apply(mk(1, 1, 16'h0601, 0, 0, 1, 8'hBB,        0, 1, 22'h000601, 8'hAA, 0, 8'h00, 0), "chg4");
        apply(mk(1, 1, 16'h0601, 0, 0, 0, 0,            1, 0, 22'h000601, 8'hBB, 0, 8'h00, 0), "chg5");
        apply(mk(1, 0, 16'h0601, 0, 0, 0, 0,            1, 0, 22'h000601, 8'hBB, 0, 8'h00, 0), "chg6");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
